// File: rtl/aes_job_sequencer_if.sv
// aes_job_sequencer_if: job request, DMA block handshake and AES control-unit signals.
interface aes_job_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             job_valid;
  logic             job_ready;
  logic [1:0]       job_op;
  logic [1:0]       job_aes_mode;
  logic [CNT_W-1:0] job_blocks;
  logic             job_abort;
  logic             din_req;
  logic             din_ack;
  logic             dout_req;
  logic             dout_ack;
  logic             core_start;
  logic [1:0]       core_op;
  logic [1:0]       core_aes_mode;
  logic             core_disable;
  logic             core_end_comp;
  logic             busy;
  logic             job_done;
  logic             job_err;
  logic [CNT_W-1:0] blocks_left;
  modport master (
    output job_valid, job_op, job_aes_mode, job_blocks, job_abort, din_ack, dout_ack, core_end_comp,
    input  job_ready, din_req, dout_req, core_start, core_op, core_aes_mode, core_disable,
           busy, job_done, job_err, blocks_left
  );
  modport slave (
    input  job_valid, job_op, job_aes_mode, job_blocks, job_abort, din_ack, dout_ack, core_end_comp,
    output job_ready, din_req, dout_req, core_start, core_op, core_aes_mode, core_disable,
           busy, job_done, job_err, blocks_left
  );
endinterface

// File: rtl/aes_job_sequencer.sv
// aes_job_sequencer: steps multi-block AES jobs through fetch/start/wait/drain,
// with key-only jobs, abort requests and a completion watchdog.
module aes_job_sequencer #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 63
) (
  input logic                clk,
  input logic                rst_n,
  aes_job_sequencer_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, START, WAIT, DRAIN, DONE, ABORT} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] blocks_q, blocks_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [1:0]       op_q, op_d, mode_q, mode_d;
  logic             key_q, key_d;
  logic             ready_q, din_req_q, dout_req_q, start_q, abort_q, done_q;
  logic             timeout;
  // The TIMEOUT-th WAIT cycle aborts even if end_comp arrives in it.
  assign timeout = (state_q == WAIT) && (wd_q >= WD_W'(TIMEOUT - 1));
  always_comb begin
    state_d  = state_q;
    blocks_d = blocks_q;
    op_d     = op_q;
    mode_d   = mode_q;
    key_d    = key_q;
    wd_d     = (state_q == START) ? '0 :
               (state_q == WAIT && wd_q != WD_W'(TIMEOUT)) ? wd_q + 1'b1 : wd_q;
    case (state_q)
      IDLE:  if (bus.job_valid) begin
        op_d     = bus.job_op;
        mode_d   = bus.job_aes_mode;
        key_d    = bus.job_op == 2'b01;
        blocks_d = bus.job_blocks;
        state_d  = (bus.job_op == 2'b01) ? START : (bus.job_blocks == '0) ? DONE : FETCH;
      end
      FETCH: if (bus.din_ack) state_d = START;
      START: state_d = WAIT;
      WAIT:  if (bus.core_end_comp) begin
        state_d = key_q ? DONE : DRAIN;
        // Key is derived after the first block, so the rest of the job is plain decrypt.
        if (op_q == 2'b11) op_d = 2'b10;
      end
      DRAIN: if (bus.dout_ack) begin
        blocks_d = blocks_q - CNT_W'(blocks_q != '0);
        state_d  = (blocks_q <= CNT_W'(1)) ? DONE : FETCH;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && state_q != ABORT && (bus.job_abort || timeout)) begin
      state_d  = ABORT;
      blocks_d = '0;
      op_d     = op_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      blocks_q   <= '0;
      wd_q       <= '0;
      op_q       <= '0;
      mode_q     <= '0;
      key_q      <= 1'b0;
      ready_q    <= 1'b1;
      din_req_q  <= 1'b0;
      dout_req_q <= 1'b0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      blocks_q   <= blocks_d;
      wd_q       <= wd_d;
      op_q       <= op_d;
      mode_q     <= mode_d;
      key_q      <= key_d;
      ready_q    <= state_d == IDLE;
      din_req_q  <= state_d == FETCH;
      dout_req_q <= state_d == DRAIN;
      start_q    <= state_d == START;
      abort_q    <= state_d == ABORT;
      done_q     <= state_d == DONE;
    end
  end
  assign bus.job_ready     = ready_q;
  assign bus.busy          = !ready_q;
  assign bus.din_req       = din_req_q;
  assign bus.dout_req      = dout_req_q;
  assign bus.core_start    = start_q;
  assign bus.core_op       = op_q;
  assign bus.core_aes_mode = mode_q;
  assign bus.core_disable  = abort_q;
  assign bus.job_err       = abort_q;
  assign bus.job_done      = done_q;
  assign bus.blocks_left   = blocks_q;
endmodule

// File: doc/aes_job_sequencer.md
# aes_job_sequencer

Multi-block job sequencer sitting between the host/DMA side and the AES control unit. Accepts a job (operation, AES mode, block count), then for each 128-bit block fetches input via a DMA-style handshake, pulses the core `start`, waits for `end_comp`, and drains the output block. It also handles key-derivation-only jobs, the switch from decrypt-with-derivation to plain decrypt after the first block, abort requests and a completion watchdog.

## Interface
- `CNT_W`, default 8: width of the block counter; max job is 2^CNT_W-1 blocks.
- `TIMEOUT`, default 63: max cycles from `core_start` to `core_end_comp` before the job is aborted.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `job_valid` in 1: job request.
- `job_ready` out 1: high only in IDLE; a job is accepted when `job_valid && job_ready`.
- `job_op` in 2: operation mode (00 enc, 01 key derivation, 10 dec, 11 dec with derivation).
- `job_aes_mode` in 2: 00 ECB, 01 CBC, 10 CTR.
- `job_blocks` in CNT_W: number of blocks in the job.
- `job_abort` in 1: cancel the job in progress.
- `din_req` out 1: request that the next input block be written to the core.
- `din_ack` in 1: input block written.
- `dout_req` out 1: output block available for read.
- `dout_ack` in 1: output block read.
- `core_start` out 1: one-cycle start pulse to the control unit.
- `core_op` out 2: operation mode to the control unit.
- `core_aes_mode` out 2: AES mode to the control unit.
- `core_disable` out 1: one-cycle disable pulse to the control unit.
- `core_end_comp` in 1: completion pulse from the control unit.
- `busy` out 1: high when not IDLE.
- `job_done` out 1: one-cycle pulse on normal completion.
- `job_err` out 1: one-cycle pulse on abort or timeout.
- `blocks_left` out CNT_W: blocks not yet drained.

## Operation
States: IDLE, FETCH, START, WAIT, DRAIN, DONE, ABORT.

- **IDLE**
  - On accept, latch op/mode into `core_op`/`core_aes_mode`, set a key-only flag (op==01) and load `blocks_left` = `job_blocks`.
  - Next state: op==01 → START; else `job_blocks`==0 → DONE; else → FETCH.
- **FETCH**: `din_req`=1 until `din_ack` → START.
- **START**: `core_start`=1 for exactly this cycle; watchdog cleared → WAIT.
- **WAIT**: watchdog increments each cycle.
  - On `core_end_comp`: key-only → DONE; else → DRAIN.
  - If the first `core_end_comp` arrives while `core_op`==11, `core_op` becomes 10 for the rest of the job, since the key is already derived.
- **DRAIN**: `dout_req`=1 until `dout_ack`.
  - On ack, `blocks_left` decrements.
  - If it was 1 → DONE; else → FETCH.
- **DONE**: `job_done`=1 for one cycle → IDLE.
- **ABORT**: `core_disable`=1 and `job_err`=1 for one cycle → IDLE; `blocks_left` cleared.
- **Abort entry**: from any non-IDLE state other than ABORT, on `job_abort`=1 or on watchdog reaching TIMEOUT in WAIT.
- `core_op`/`core_aes_mode` are held stable from accept until the next accept. The 11→10 change is the only exception.
- CBC chaining and CTR counter increment are left to the core. The sequencer only keeps the mode stable across blocks.

## Timing
- **Reset values**: state IDLE; `job_ready`=1; all other outputs 0, including `core_op`, `core_aes_mode` and `blocks_left`.
- **Latencies** (edge t):
  - Job accepted at t → `din_req` high from t+1.
  - `din_ack` at t → `core_start` in cycle t+1.
  - `core_end_comp` at t → `dout_req` from t+1.
  - Last `dout_ack` at t → `job_done` at t+1, `job_ready` at t+2.
- **Handshakes**: `din_req`/`dout_req` are held until acked. Acks are ignored when the matching req is low; `core_end_comp` outside WAIT is ignored.
- **Simultaneous events**: `job_abort` beats any ack or `core_end_comp` in the same cycle. Timeout is checked before `core_end_comp`: `core_end_comp` arriving exactly on the TIMEOUT-th cycle still aborts.
- **`job_abort` in IDLE**: ignored, and a job presented in the same cycle is accepted.
- **Async reset mid-job**: immediate return to IDLE with reset values; no `job_err` or `core_disable` pulse.
- **Counter widths**: `blocks_left` decrements only on `dout_ack` and never wraps. The watchdog is wide enough to count to TIMEOUT and saturates.

## Test plan
- **Encrypt ECB, 3 blocks**: op 00, mode 00, `job_blocks`=3, core model returns `end_comp` 44 cycles after start → 3 FETCH/START/WAIT/DRAIN loops; `blocks_left` 3→2→1→0; one `job_done`; `core_op` stays 00.
- **Decrypt with derivation, 2 blocks, CBC**: `core_op`=11 for the first `core_start`, 10 for the second; `core_aes_mode`=01 throughout; `job_done` once.
- **Key derivation only**: op 01, `job_blocks`=5 → single `core_start`, no `din_req`/`dout_req`, `job_done` 1 cycle after `end_comp`, `blocks_left` reads 5 until the next accept.
- **Zero-length job**: `job_blocks`=0, op 00 → `job_done` the cycle after accept, no `core_start`.
- **Timeout and abort**:
  - Core never returns `end_comp` → `core_disable` and `job_err` exactly TIMEOUT cycles after WAIT entry; `job_ready` on the next cycle.
  - Separately, `job_abort` asserted in the same cycle as `dout_ack` → ABORT, no `job_done`.
- **Reset mid-WAIT**: `rst_n` low during WAIT of block 2 → all outputs at reset values immediately; a new job accepted after release runs normally.
